dmm_mem_responder: RTL
======================

// Module: dmm_mem_responder
// PURPOSE
//  Responder (memory-side) end of the dmm_unit request interface driven by memory_manager.
//  - Accepts one strobe/addr/rw/size/data request at a time.
//  - Splits the request into 32-bit beats on a single-port word SRAM.
//  - Returns a one-cycle done pulse and, for reads, the 256-bit read data.
//  - Sits between the memory manager / atomic unit mux and the heap scratchpad.
// PARAMETERS
//  BASE_ADDR   32'h70000000  byte address mapped to SRAM word 0
//  MEM_WORDS   32'h00800000  SRAM depth in 32-bit words (power of 2)
//  MEM_AW      23            SRAM word-address width, = log2(MEM_WORDS)
//  MEM_RD_LAT  1             fixed SRAM read latency in cycles (1..4)
// PORTS
//  clk          in   1    clock; all logic on rising edge
//  rst          in   1    reset: asynchronous, active-low (asserted when 0)
//  req_strobe   in   1    request valid; held by initiator until done
//  req_addr     in   32   byte address; must be 4-byte aligned
//  req_rw       in   1    1 = write, 0 = read
//  req_data     in   256  write data, MSB-packed: beat k = req_data[255-32k -: 32]
//  req_size     in   8    transfer length in bytes, 0..32
//  resp_done    out  1    one-cycle completion pulse
//  resp_data    out  256  read data, MSB-packed like req_data; unused lanes 0
//  resp_err     out  1    valid with resp_done: request rejected, no SRAM access
//  mem_en       out  1    SRAM access enable
//  mem_we       out  1    SRAM write enable (qualified by mem_en)
//  mem_addr     out  MEM_AW  SRAM word address
//  mem_be       out  4    byte enables; bit i enables mem_wdata[8i+7:8i]
//  mem_wdata    out  32   SRAM write data
//  mem_rdata    in   32   SRAM read data, valid MEM_RD_LAT cycles after read issue
//  stat_rd_cnt  out  32   completed read requests (see CONFIGURATION)
//  stat_wr_cnt  out  32   completed write requests (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE.
//  Request rules:
//  - Accept edge E0 = first rising edge in IDLE with req_strobe = 1.
//  - addr/rw/size/data are registered at E0; later input changes are ignored until done.
//  - Beat count N = ceil(size/4), 1..8.
//  - Error (resp_err = 1) if any of: addr[1:0] != 0; size > 32;
//    addr < BASE_ADDR; (addr - BASE_ADDR) / 4 + N > MEM_WORDS.
//  - Error and size = 0: resp_done in cycle E0+1; no SRAM access; resp_data unchanged.
//  FSM states: IDLE -> RD_ISSUE | WR_ISSUE | DONE(err / size 0) -> DONE -> IDLE.
//  Write (WR_ISSUE):
//  - Beat k in cycle E0+1+k: mem_en = mem_we = 1, mem_addr = word base + k,
//    mem_wdata = beat k.
//  - mem_be = 4'hF, except the last beat: low (size - 4(N-1)) lanes set.
//  - resp_done in cycle E0+N+1.
//  Read:
//  - RD_ISSUE issues beat k in cycle E0+1+k, mem_be = 4'hF, back-to-back.
//  - RD_WAIT captures mem_rdata MEM_RD_LAT cycles after each issue into lane k
//    using a separate capture counter.
//  - Lanes >= N are zeroed; a partial last beat is returned whole.
//  - resp_done in cycle E0+N+MEM_RD_LAT+1.
//  - resp_data is updated only by reads; held stable from done until the next read's first capture.
//  DONE lasts exactly 1 cycle, then IDLE.
//  - Initiator protocol: strobe drops in the cycle after done.
//  - A strobe seen in that IDLE cycle is a new request (back-to-back allowed).
//  Address math: word base = (addr - BASE_ADDR) >> 2, truncated to MEM_AW bits after the range check.
//  Reset mid-operation:
//  - FSM, counters and mem_en go to 0 immediately.
//  - In-flight SRAM reads are discarded; no resp_done for the aborted request.
// CONFIGURATION
//  DMM_RESP_STATS_EN defined:
//  - stat_rd_cnt / stat_wr_cnt increment in the resp_done cycle of each non-error
//    read / write (size 0 counts); they wrap at 2^32 and reset to 0.
//  DMM_RESP_STATS_EN undefined:
//  - Both outputs tied to 0; no counter flops.
// TESTING
//  1. Write 0x70000000, size 4, data[255:224] = 0xDEADBEEF
//     -> 1 beat: mem_addr 0, be F, wdata DEADBEEF; done at E0+2, err 0.
//  2. Read 0x70000000, size 4, LAT 1 after test 1
//     -> resp_data[255:224] = DEADBEEF, rest 0; done at E0+3.
//  3. Write size 30 at 0x70000010
//     -> 8 beats at mem_addr 4..11; last be = 4'b0011; done at E0+9.
//     Read back size 32 -> bytes match, last 2 bytes = prior SRAM content.
//  4. Addr 0x70000002, and separately addr 0x6FFFFFFC
//     -> done at E0+1, err 1, mem_en never high, resp_data unchanged.
//  5. Two back-to-back reads, strobe dropped 1 cycle after each done
//     -> two done pulses, no duplicate accept.
//     With MEM_RD_LAT 3, 8-beat read -> done at E0+12.
//  6. rst low during beat 3 of an 8-beat read
//     -> mem_en 0 at once, no done; next request completes normally.
//     With DMM_RESP_STATS_EN -> counts reflect completed requests only.

Source files
------------

// File: rtl/dmm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmm_mem_responder
// Brief    : Memory-side responder for the dmm_unit request interface. Splits
//            one request (up to 32 bytes) into 32-bit beats on a single-port
//            word SRAM and returns a one-cycle done pulse plus read data.
//            Optional request statistics: define DMM_RESP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmm_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h7000_0000,
  parameter logic [31:0] MEM_WORDS  = 32'h0080_0000,
  parameter int          MEM_AW     = 23,
  parameter int          MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_strobe,
  input  logic [31:0]       req_addr,
  input  logic              req_rw,
  input  logic [255:0]      req_data,
  input  logic [7:0]        req_size,
  output logic              resp_done,
  output logic [255:0]      resp_data,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_accept;
  logic              w_err;
  logic              w_size_zero;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_capture;
  logic              w_last_capture;
  logic [3:0]        w_nbeats;
  logic [3:0]        w_last_be;
  logic [29:0]       w_word_off;
  logic [32:0]       w_end;
  logic [31:0]       w_beat_word;

  logic              r_err;
  logic [3:0]        r_nbeats;
  logic [3:0]        r_last_be;
  logic [3:0]        r_beat;
  logic [3:0]        r_cap_cnt;
  logic [MEM_AW-1:0] r_word_base;
  logic [255:0]      r_wdata;
  logic [255:0]      r_rdata;
  logic [MEM_RD_LAT-1:0] r_cap_pipe;

  // Request decode: beat count and the range check use a 33-bit end word so
  // a request running past the top of the SRAM cannot wrap into range.
  assign w_accept    = (r_state == S_IDLE) && req_strobe;
  assign w_size_zero = (req_size == 8'd0);
  assign w_nbeats    = req_size[5:2] + {3'b000, |req_size[1:0]};
  assign w_word_off  = req_addr[31:2] - BASE_ADDR[31:2];
  assign w_end       = {3'b000, w_word_off} + {29'd0, w_nbeats};
  assign w_err       = (req_addr[1:0] != 2'b00) || (req_size > 8'd32) ||
                       (req_addr < BASE_ADDR) || (w_end > {1'b0, MEM_WORDS});

  // Byte enables of the final write beat: only the bytes still owed are set.
  always_comb begin
    w_last_be = 4'hF;
    case (req_size[1:0])
      2'b01:   w_last_be = 4'b0001;
      2'b10:   w_last_be = 4'b0011;
      2'b11:   w_last_be = 4'b0111;
      default: w_last_be = 4'hF;
    endcase
  end

  assign w_issue        = (r_state == S_RD_ISSUE) || (r_state == S_WR_ISSUE);
  assign w_last_issue   = w_issue && (r_beat == r_nbeats - 4'd1);
  assign w_capture      = r_cap_pipe[MEM_RD_LAT-1];
  assign w_last_capture = w_capture && (r_cap_cnt == r_nbeats - 4'd1);
  // Beat k lives at bits [255-32k -: 32], i.e. base offset 32*(7-k).
  assign w_beat_word    = r_wdata[{~r_beat[2:0], 5'b00000} +: 32];

  // State register; async reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and SRAM/response strobes.
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    resp_done = 1'b0;
    resp_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_strobe) begin
          if (w_err || w_size_zero) w_next = S_DONE;
          else if (req_rw)          w_next = S_WR_ISSUE;
          else                      w_next = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = r_word_base + MEM_AW'(r_beat);
        mem_be   = 4'hF;
        if (w_last_issue) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_last_capture) w_next = S_DONE;
      end
      S_WR_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_word_base + MEM_AW'(r_beat);
        mem_be    = w_last_issue ? r_last_be : 4'hF;
        mem_wdata = w_beat_word;
        if (w_last_issue) w_next = S_DONE;
      end
      S_DONE: begin
        resp_done = 1'b1;
        resp_err  = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, beat/capture counters and read-data assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err       <= 1'b0;
      r_nbeats    <= 4'd0;
      r_last_be   <= 4'h0;
      r_beat      <= 4'd0;
      r_cap_cnt   <= 4'd0;
      r_word_base <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cap_pipe  <= '0;
    end else begin
      r_cap_pipe[0] <= (r_state == S_RD_ISSUE);
      for (int i = 1; i < MEM_RD_LAT; i++) r_cap_pipe[i] <= r_cap_pipe[i-1];
      if (w_accept) begin
        r_err       <= w_err;
        r_nbeats    <= w_nbeats;
        r_last_be   <= w_last_be;
        r_beat      <= 4'd0;
        r_cap_cnt   <= 4'd0;
        r_word_base <= w_word_off[MEM_AW-1:0];
        r_wdata     <= req_data;
      end else begin
        if (w_issue) r_beat <= r_beat + 4'd1;
        if (w_capture) begin
          r_cap_cnt <= r_cap_cnt + 4'd1;
          // The first capture of a read also clears lanes the read won't fill.
          for (int k = 0; k < 8; k++) begin
            if (r_cap_cnt == 4'(k))        r_rdata[32*(7-k) +: 32] <= mem_rdata;
            else if (r_cap_cnt == 4'd0)    r_rdata[32*(7-k) +: 32] <= 32'h0;
          end
        end
      end
    end
  end

  assign resp_data = r_rdata;

`ifdef DMM_RESP_STATS_EN
  logic        r_rw;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;

  // Count successful requests (including size 0) in their done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rw      <= 1'b0;
      r_stat_rd <= 32'd0;
      r_stat_wr <= 32'd0;
    end else begin
      if (w_accept) r_rw <= req_rw;
      if ((r_state == S_DONE) && !r_err) begin
        if (r_rw) r_stat_wr <= r_stat_wr + 32'd1;
        else      r_stat_rd <= r_stat_rd + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = r_stat_rd;
  assign stat_wr_cnt = r_stat_wr;
`else
  assign stat_rd_cnt = 32'd0;
  assign stat_wr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
